adder_share_arbiter: RTL and testbench

- Shares the single 32-bit carry-lookahead adder between two requesters: req0 = ALU add/sub path, req1 = PC/address-increment path.
- Arbitrates between them, latches operands, and drives the adder (B inversion plus Cin=1 for subtract).
- Registers sum, carry and overflow, and returns the result on one response channel tagged with the requester ID.
- Sits between the control unit and the ALU datapath.

---
 rtl/adder_share_arbiter_pkg.sv | 17 +
 rtl/adder_share_arbiter_cla.sv | 42 ++++
 rtl/adder_share_arbiter.sv | 113 +++++++++++
 tb/tb_adder_share_arbiter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_share_arbiter_pkg.sv
// Shared constants for the adder-sharing arbiter: FSM encodings, requester IDs
// and the signed-overflow rule used on the shared adder's result.
package adder_share_arbiter_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic REQ_ALU = 1'b0;
  localparam logic REQ_PC  = 1'b1;

  // Two's-complement overflow: operands agree in sign, result does not.
  function automatic logic ovf_of(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/adder_share_arbiter_cla.sv
// 32-bit carry-lookahead adder: 4-bit lookahead groups chained through a
// group-level generate/propagate carry network.
module adder_share_arbiter_cla (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  logic [31:0] g;
  logic [31:0] p;
  logic [31:0] c;
  logic [7:0]  gg;
  logic [7:0]  gp;
  logic [8:0]  gc;

  assign g = a & b;
  assign p = a ^ b;

  for (genvar k = 0; k < 8; k++) begin : g_grp
    localparam int B = 4 * k;
    assign gg[k] = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1])
                 | (p[B+3] & p[B+2] & p[B+1] & g[B]);
    assign gp[k] = &p[B+3:B];
    assign c[B]   = gc[k];
    assign c[B+1] = g[B] | (p[B] & gc[k]);
    assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & gc[k]);
    assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                  | (p[B+2] & p[B+1] & p[B] & gc[k]);
  end

  always_comb begin
    gc    = '0;
    gc[0] = cin;
    for (int k = 0; k < 8; k++) gc[k+1] = gg[k] | (gp[k] & gc[k]);
  end

  assign sum  = p ^ c;
  assign cout = gc[8];

endmodule

// File: rtl/adder_share_arbiter.sv
// Arbitrates the ALU and PC-increment paths onto one shared 32-bit adder and
// returns each result, tagged with its requester ID, on a single response channel.
module adder_share_arbiter
  import adder_share_arbiter_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_sub,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_sub,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout,
  output logic             rsp_ovf,
  output logic [1:0]       dbg_state,
  output logic             dbg_rr_ptr
);

  if (WIDTH != 32) begin : g_bad_width
    $error("adder_share_arbiter: WIDTH must be 32 to match the shared adder");
  end

  logic [1:0]       state;
  logic             rr_ptr;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_sub;
  logic             op_id;
  logic             grant_id;
  logic             accept;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout;

  // Handshake: a request transfers on a cycle where its valid and ready are both
  // high; ready is only offered in IDLE out of reset and only to the granted
  // requester. The response transfers when rsp_valid and rsp_ready are both high.
  always_comb begin
    grant_id = REQ_ALU;
    if (req0_valid && req1_valid) grant_id = FIXED_PRIO ? REQ_ALU : rr_ptr;
    else if (req1_valid)          grant_id = REQ_PC;
  end

  assign accept     = clr && (state == ST_IDLE);
  assign req0_ready = accept && req0_valid && (grant_id == REQ_ALU);
  assign req1_ready = accept && req1_valid && (grant_id == REQ_PC);

  assign b_eff = op_sub ? ~op_b : op_b;

  adder_share_arbiter_cla u_cla (
    .a    (op_a),
    .b    (b_eff),
    .cin  (op_sub),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_ff @(posedge clk) begin
    if (!clr) begin
      state    <= ST_IDLE;
      rr_ptr   <= 1'b0;
      op_a     <= '0;
      op_b     <= '0;
      op_sub   <= 1'b0;
      op_id    <= REQ_ALU;
      rsp_id   <= 1'b0;
      rsp_sum  <= '0;
      rsp_cout <= 1'b0;
      rsp_ovf  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req0_valid || req1_valid) begin
            op_a   <= (grant_id == REQ_PC) ? req1_a   : req0_a;
            op_b   <= (grant_id == REQ_PC) ? req1_b   : req0_b;
            op_sub <= (grant_id == REQ_PC) ? req1_sub : req0_sub;
            op_id  <= grant_id;
            rr_ptr <= ~grant_id;
            state  <= ST_CALC;
          end
        end
        ST_CALC: begin
          rsp_sum  <= add_sum;
          rsp_cout <= add_cout;
          rsp_ovf  <= ovf_of(op_a[WIDTH-1], b_eff[WIDTH-1], add_sum[WIDTH-1]);
          rsp_id   <= op_id;
          state    <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign rsp_valid  = (state == ST_RESP);
  assign dbg_state  = state;
  assign dbg_rr_ptr = rr_ptr;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Bench for adder_share_arbiter: round-robin and fixed-priority instances share a
// clock/reset and are checked every cycle against a transaction-level model.
module tb_adder_share_arbiter;

  localparam longint SMAX = 2147483647;
  localparam longint SMIN = -SMAX - 1;

  logic clk = 1'b0;
  logic clr;

  // Requester j = 2*k + r : instance k (0 = round-robin, 1 = fixed priority), port r.
  logic [3:0]       q_valid, q_sub, q_ready;
  logic [3:0][31:0] q_a, q_b;
  logic [1:0]       rsp_rdy, rsp_valid, rsp_id, rsp_cout, rsp_ovf, dbg_rr;
  logic [1:0][31:0] rsp_sum;
  logic [1:0][1:0]  dbg_state;

  always #5 clk = ~clk;

  adder_share_arbiter #(.WIDTH(32), .FIXED_PRIO(1'b0)) u_rr (
    .clk(clk), .clr(clr),
    .req0_valid(q_valid[0]), .req0_ready(q_ready[0]), .req0_a(q_a[0]), .req0_b(q_b[0]), .req0_sub(q_sub[0]),
    .req1_valid(q_valid[1]), .req1_ready(q_ready[1]), .req1_a(q_a[1]), .req1_b(q_b[1]), .req1_sub(q_sub[1]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_rdy[0]), .rsp_id(rsp_id[0]), .rsp_sum(rsp_sum[0]),
    .rsp_cout(rsp_cout[0]), .rsp_ovf(rsp_ovf[0]), .dbg_state(dbg_state[0]), .dbg_rr_ptr(dbg_rr[0])
  );

  adder_share_arbiter #(.WIDTH(32), .FIXED_PRIO(1'b1)) u_fp (
    .clk(clk), .clr(clr),
    .req0_valid(q_valid[2]), .req0_ready(q_ready[2]), .req0_a(q_a[2]), .req0_b(q_b[2]), .req0_sub(q_sub[2]),
    .req1_valid(q_valid[3]), .req1_ready(q_ready[3]), .req1_a(q_a[3]), .req1_b(q_b[3]), .req1_sub(q_sub[3]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_rdy[1]), .rsp_id(rsp_id[1]), .rsp_sum(rsp_sum[1]),
    .rsp_cout(rsp_cout[1]), .rsp_ovf(rsp_ovf[1]), .dbg_state(dbg_state[1]), .dbg_rr_ptr(dbg_rr[1])
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int mode = 0;     // 0 directed, 1 random, 2 both requesters always valid
  int bp_mode = 1;  // 0 random rsp_ready, 1 always ready, 2 stalled
  logic [3:0] hs_last = '0;
  bit log_en = 0;
  int glog0[$];
  int glog1[$];

  // Model state per instance: may accept, pending response, round-robin pointer.
  logic [1:0]  m_idle = 2'b11, m_pend = 2'b00, m_rr = 2'b00, m_fresh = 2'b00;
  int          m_due[2];
  logic [34:0] m_exp[2];
  logic        c_v0, c_v1, c_er0, c_er1, c_g;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Returns {ovf, cout, sum} from plain integer arithmetic.
  function automatic logic [33:0] ref_op(input logic [31:0] a, input logic [31:0] b, input logic sub);
    longint sa, sb, ua, ub, r;
    logic [31:0] s;
    logic c, o;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    if (sub) begin
      r = sa - sb; c = (ua >= ub); s = a - b;
    end else begin
      r = sa + sb; c = ((ua + ub) > 64'sd4294967295); s = a + b;
    end
    o = (r > SMAX) || (r < SMIN);
    return {o, c, s};
  endfunction

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'hFFFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  always @(negedge clk) begin
    cyc++;
    for (int k = 0; k < 2; k++) begin
      c_v0 = q_valid[2*k];
      c_v1 = q_valid[2*k+1];
      c_er0 = 1'b0; c_er1 = 1'b0; c_g = 1'b0;
      if (clr && m_idle[k] && (c_v0 || c_v1)) begin
        if (c_v0 && c_v1) c_g = (k == 1) ? 1'b0 : m_rr[k];
        else              c_g = c_v1;
        c_er0 = ~c_g;
        c_er1 = c_g;
      end
      chk($sformatf("req0_ready[%0d]", k), 64'(q_ready[2*k]), 64'(c_er0));
      chk($sformatf("req1_ready[%0d]", k), 64'(q_ready[2*k+1]), 64'(c_er1));
      if (!clr) begin
        m_idle[k] = 1'b1; m_pend[k] = 1'b0; m_rr[k] = 1'b0; m_fresh[k] = 1'b1;
      end else begin
        if (m_fresh[k]) begin
          chk($sformatf("reset_state[%0d]", k), 64'(dbg_state[k]), 64'd0);
          chk($sformatf("reset_rr[%0d]", k), 64'(dbg_rr[k]), 64'd0);
          chk($sformatf("reset_rsp[%0d]", k),
              {29'd0, rsp_valid[k], rsp_id[k], rsp_ovf[k], rsp_cout[k], rsp_sum[k]}, 64'd0);
          m_fresh[k] = 1'b0;
        end else if (m_pend[k] && cyc >= m_due[k]) begin
          chk($sformatf("rsp_valid[%0d]", k), 64'(rsp_valid[k]), 64'd1);
          chk($sformatf("rsp_data[%0d]", k),
              64'({rsp_id[k], rsp_ovf[k], rsp_cout[k], rsp_sum[k]}), 64'(m_exp[k]));
          if (rsp_rdy[k]) begin
            m_pend[k] = 1'b0; m_idle[k] = 1'b1;
          end
        end else begin
          chk($sformatf("rsp_idle[%0d]", k), 64'(rsp_valid[k]), 64'd0);
        end
        if ((c_er0 && c_v0) || (c_er1 && c_v1)) begin
          m_exp[k]  = {c_g, ref_op(q_a[2*k+c_g], q_b[2*k+c_g], q_sub[2*k+c_g])};
          m_pend[k] = 1'b1;
          m_due[k]  = cyc + 2;
          m_idle[k] = 1'b0;
          m_rr[k]   = ~c_g;
          if (log_en) begin
            if (k == 0) glog0.push_back(int'(c_g));
            else        glog1.push_back(int'(c_g));
          end
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    for (int j = 0; j < 4; j++) hs_last[j] = q_valid[j] & q_ready[j];
    @(posedge clk);
    #1;
    case (bp_mode)
      0: rsp_rdy = {1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0)};
      1: rsp_rdy = 2'b11;
      default: rsp_rdy = 2'b00;
    endcase
    if (mode != 0) begin
      for (int j = 0; j < 4; j++) begin
        if (q_valid[j] && !hs_last[j]) begin
          if (mode == 1 && $urandom_range(0, 7) == 0) q_valid[j] = 1'b0;
        end else begin
          q_valid[j] = (mode == 2) ? 1'b1 : 1'($urandom_range(0, 1));
          q_a[j]     = rand_word();
          q_b[j]     = rand_word();
          q_sub[j]   = 1'($urandom_range(0, 1));
        end
      end
    end
  endtask

  // Presents the same request on port r of both instances and waits for both grants.
  task automatic issue_both(input int r, input logic [31:0] a, input logic [31:0] b, input logic sub);
    logic [1:0] done;
    done = 2'b00;
    for (int k = 0; k < 2; k++) begin
      q_valid[2*k+r] = 1'b1; q_a[2*k+r] = a; q_b[2*k+r] = b; q_sub[2*k+r] = sub;
    end
    for (int t = 0; t < 40 && done != 2'b11; t++) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        if (!done[k] && hs_last[2*k+r]) begin
          done[k] = 1'b1;
          q_valid[2*k+r] = 1'b0;
        end
      end
    end
    chk("issue_granted", 64'(done), 64'd3);
  endtask

  initial begin
    clr = 1'b0;
    q_valid = '0; q_sub = '0; q_a = '0; q_b = '0;
    rsp_rdy = 2'b11;

    chk("model_add_1_1",   64'(ref_op(32'h0000_0001, 32'h0000_0001, 1'b0)), {30'd0, 2'b00, 32'h0000_0002});
    chk("model_sub_3_5",   64'(ref_op(32'h0000_0003, 32'h0000_0005, 1'b1)), {30'd0, 2'b00, 32'hFFFF_FFFE});
    chk("model_sub_5_3",   64'(ref_op(32'h0000_0005, 32'h0000_0003, 1'b1)), {30'd0, 2'b01, 32'h0000_0002});
    chk("model_add_ovf",   64'(ref_op(32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0)), {30'd0, 2'b10, 32'hFFFF_FFFE});
    chk("model_add_wrap",  64'(ref_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0)), {30'd0, 2'b01, 32'h0000_0000});
    chk("model_sub_ovf",   64'(ref_op(32'h8000_0000, 32'h0000_0001, 1'b1)), {30'd0, 2'b11, 32'h7FFF_FFFF});

    repeat (3) tick();
    clr = 1'b1;

    issue_both(0, 32'h0000_0001, 32'h0000_0001, 1'b0);
    issue_both(1, 32'h0000_0003, 32'h0000_0005, 1'b1);
    issue_both(1, 32'h0000_0005, 32'h0000_0003, 1'b1);
    issue_both(0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0);
    issue_both(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    repeat (4) tick();

    // Reset lands while both instances are computing 5+3.
    issue_both(0, 32'h0000_0005, 32'h0000_0003, 1'b0);
    clr = 1'b0;
    tick();
    clr = 1'b1;
    repeat (2) tick();
    issue_both(0, 32'h0000_0005, 32'h0000_0003, 1'b0);
    repeat (4) tick();

    // Both requesters valid continuously from a fresh reset.
    clr = 1'b0;
    mode = 2;
    glog0.delete();
    glog1.delete();
    log_en = 1;
    tick();
    clr = 1'b1;
    repeat (16) tick();
    log_en = 0;
    chk("rr_grant_count", 64'(glog0.size() >= 4), 64'd1);
    chk("fp_grant_count", 64'(glog1.size() >= 4), 64'd1);
    if (glog0.size() >= 4 && glog1.size() >= 4) begin
      chk("rr_grant_seq", {glog0[0][15:0], glog0[1][15:0], glog0[2][15:0], glog0[3][15:0]}, 64'h0000_0001_0000_0001);
      chk("fp_grant_seq", {glog1[0][15:0], glog1[1][15:0], glog1[2][15:0], glog1[3][15:0]}, 64'h0);
    end

    bp_mode = 2;
    repeat (8) tick();
    bp_mode = 1;
    repeat (6) tick();

    mode = 1;
    bp_mode = 0;
    repeat (800) tick();

    mode = 0;
    bp_mode = 1;
    q_valid = '0;
    repeat (5) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
